sprite_rom_scheduler: RTL and testbench
=======================================

Name: sprite_rom_scheduler

Overview:
- Shares one synchronous-read sprite ROM port (32x32 sprite, 1024 words, 1-cycle read latency) among NREQ requesters, e.g. player, sword, enemy and NPC draw units.
- Requester 0 is the VGA pixel path and has fixed priority. All other requesters are served round-robin, with a starvation guard that forces service.
- Sits between the sprite draw logic and a single shared sprite ROM instance. Return data is tagged back to the requester that was granted.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 10, ROM address width.
- DW, 4, ROM data width.
- STARVE_MAX, 6, number of consecutive blocked cycles after which a low-priority requester preempts requester 0.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester read request; held high until granted.
- addr  in  NREQ*AW  packed addresses; requester i occupies bits [i*AW +: AW].
- gnt  out  NREQ  one-hot, combinational; request accepted this cycle.
- rd_valid  out  NREQ  one-hot, registered; rd_data belongs to this requester.
- rd_data  out  DW  ROM data returned for the granted request.
- rom_addr  out  AW  address to the shared ROM (combinational mux).
- rom_q  in  DW  ROM output; registered inside the ROM.
- busy_cnt  out  16  number of grants issued since reset; wraps.

Behaviour:
- Reset (async, reset_n=0): rd_valid=0, rr_ptr=1, all starve counters=0, busy_cnt=0, tag=0.
  - gnt=0 and rom_addr=0 while reset_n=0.
  - Any in-flight read is discarded; no rd_valid is issued for it after release.
- Exactly one grant per cycle when any req is high; gnt=0 when no req is high.
- Grant selection, in priority order:
  1. Forced grant: if any requester i≥1 has starve[i]≥STARVE_MAX and req[i]=1, grant the lowest such i, even over req[0].
  2. Otherwise, if req[0]=1, grant requester 0.
  3. Otherwise, grant the first requester with req high, searching from rr_ptr upward over indices 1..NREQ-1 and wrapping back to 1 (index 0 is skipped).
- rom_addr equals addr of the granted requester in the same cycle.
  - The ROM samples rom_addr at the next posedge.
  - rom_q is therefore valid in cycle t+1 for a grant in cycle t.
- Return path (latency 1):
  - At posedge, tag <= gnt and rd_valid <= gnt.
  - rd_data = rom_q, passed through combinationally and qualified by rd_valid.
  - Back-to-back grants give one result per cycle with no bubbles.
- rr_ptr update:
  - After a grant to requester i≥1 (normal or forced), rr_ptr <= i+1, wrapping NREQ to 1.
  - Unchanged after a grant to requester 0.
- Starve counters (requesters 1..NREQ-1 only):
  - If req[i]=1 and gnt[i]=0: increment, saturating at STARVE_MAX.
  - If gnt[i]=1 or req[i]=0: clear to 0.
- Requester rules:
  - req and addr must stay stable until gnt is seen.
  - Deasserting req before grant is legal and cancels the request, with no response.
  - A requester may re-request in the cycle after its grant.
- busy_cnt: +1 per cycle with any gnt high; wraps from 0xFFFF to 0.
- Simultaneous forced candidates: lowest index wins. The other forced candidates keep their saturated counters and win on later cycles.
- NREQ=2: round-robin degenerates to requester 1 only; the starvation guard still applies.

Test Plan:
- Reset release, no requests: gnt=0 and rd_valid=0 for 10 cycles; busy_cnt=0.
- req[0]=1, addr0=0x155 for one cycle: gnt=0001 and rom_addr=0x155 that cycle; next cycle rd_valid=0001, rd_data equals ROM[0x155].
- req[1..3] held high continuously with req[0]=0: grant order 1,2,3,1,2,3; rd_valid follows one cycle later; busy_cnt=6 after 6 cycles.
- req[0] held high continuously, req[2]=1 held: req[0] is granted for 6 cycles, then gnt=0100 on cycle 7 (forced). Next cycle req[0] is granted again and starve[2] is cleared.
- Back-to-back: req[0] addresses 0,1,2,3 on consecutive cycles: rd_data streams ROM[0..3] on cycles 1-4 with rd_valid continuously high.
- reset_n pulsed low in the cycle after a grant: rd_valid drops immediately, no stale rd_valid after release, rr_ptr=1.

Source files
------------

// File: rtl/sprite_rom_scheduler.sv
// Arbitrates one synchronous-read sprite ROM port among NREQ draw units.
// Requester 0 (pixel path) has priority; others round-robin with a starvation override.
module sprite_rom_scheduler #(
    parameter int NREQ       = 4,
    parameter int AW         = 10,
    parameter int DW         = 4,
    parameter int STARVE_MAX = 6
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   addr,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rd_valid,
    output logic [DW-1:0]        rd_data,
    output logic [AW-1:0]        rom_addr,
    input  logic [DW-1:0]        rom_q,
    output logic [15:0]          busy_cnt
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int PW = $clog2(NREQ);

    logic [NREQ-1:0] gnt_sel;
    logic            found;
    logic [AW-1:0]   rom_addr_mux;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0] rd_valid_q;
    logic [15:0]     busy_cnt_q;
    logic [NREQ-1:1] force_vec;
    logic [SW-1:0]   starve_q [1:NREQ-1];

    // Per-requester starvation counters; saturated counters mark forced candidates.
    generate
        for (genvar gi = 1; gi < NREQ; gi++) begin : g_starve
            assign force_vec[gi] = req[gi] && (starve_q[gi] == SW'(STARVE_MAX));

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    starve_q[gi] <= '0;
                end else if (req[gi] && !gnt_sel[gi]) begin
                    if (starve_q[gi] != SW'(STARVE_MAX))
                        starve_q[gi] <= starve_q[gi] + SW'(1);
                end else begin
                    starve_q[gi] <= '0;
                end
            end
        end
    endgenerate

    always_comb begin
        gnt_sel = '0;
        found   = 1'b0;
        for (int i = 1; i < NREQ; i++) begin
            if (!found && force_vec[i]) begin
                gnt_sel[i] = 1'b1;
                found      = 1'b1;
            end
        end
        if (!found && req[0]) begin
            gnt_sel[0] = 1'b1;
            found      = 1'b1;
        end
        // Round-robin over 1..NREQ-1 starting at rr_ptr; index 0 never takes part.
        for (int k = 0; k < NREQ - 1; k++) begin
            for (int i = 1; i < NREQ; i++) begin
                if (!found && req[i] &&
                    (i == ((int'(rr_ptr_q) - 1 + k) % (NREQ - 1)) + 1)) begin
                    gnt_sel[i] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
        if (!reset_n) gnt_sel = '0;
    end

    always_comb begin
        rom_addr_mux = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_sel[i]) rom_addr_mux = rom_addr_mux | addr[i*AW +: AW];
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        for (int i = 1; i < NREQ; i++) begin
            if (gnt_sel[i]) rr_ptr_d = (i == NREQ - 1) ? PW'(1) : PW'(i + 1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q   <= PW'(1);
            rd_valid_q <= '0;
            busy_cnt_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rd_valid_q <= gnt_sel;
            busy_cnt_q <= busy_cnt_q + {15'd0, |gnt_sel};
        end
    end

    assign gnt      = gnt_sel;
    assign rom_addr = rom_addr_mux;
    assign rd_valid = rd_valid_q;
    assign rd_data  = (|rd_valid_q) ? rom_q : '0;
    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_sprite_rom_scheduler.sv
// Scoreboard bench for sprite_rom_scheduler: stimulus pushes expected returns,
// a monitor pops them whenever rd_valid is seen and checks data, owner and timing.
module tb_sprite_rom_scheduler;

    localparam int NREQ = 4;
    localparam int AW   = 10;
    localparam int DW   = 4;

    logic               clock;
    logic               reset_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rd_valid;
    logic [DW-1:0]      rd_data;
    logic [AW-1:0]      rom_addr;
    logic [DW-1:0]      rom_q;
    logic [15:0]        busy_cnt;

    typedef struct {
        int              due;
        logic [NREQ-1:0] who;
        logic [DW-1:0]   data;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   n_gr   = 0;

    sprite_rom_scheduler #(.NREQ(NREQ), .AW(AW), .DW(DW), .STARVE_MAX(6)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .req      (req),
        .addr     (addr),
        .gnt      (gnt),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rom_addr (rom_addr),
        .rom_q    (rom_q),
        .busy_cnt (busy_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [DW-1:0] rom_val(input logic [AW-1:0] a);
        return a[3:0] ^ a[7:4] ^ {a[9:8], a[9:8]} ^ 4'h5;
    endfunction

    // Behavioural ROM with one-cycle registered read.
    always @(posedge clock) rom_q <= rom_val(rom_addr);
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // One request cycle: drive at negedge, check combinational grant, push expected return.
    task automatic step(input logic [3:0] r, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                        input logic [3:0] eg, input bit push);
        logic [AW-1:0] ea;
        exp_t e;
        @(negedge clock);
        req  = r;
        addr = {a3, a2, a1, a0};
        #1;
        ea = '0;
        if (eg[0]) ea = a0;
        if (eg[1]) ea = a1;
        if (eg[2]) ea = a2;
        if (eg[3]) ea = a3;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("rom_addr", 32'(rom_addr), 32'(ea));
        $display("[TB] cyc %0d req=%b gnt=%b rom_addr=0x%0h", cyc, r, gnt, rom_addr);
        if (push && eg != 4'b0) begin
            e.due  = cyc + 1;
            e.who  = eg;
            e.data = rom_val(ea);
            exp_q.push_back(e);
            n_gr++;
        end
    endtask

    // Monitor: pops one expectation per rd_valid, flags missing or unexpected returns.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (rd_valid != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rd_valid", 32'(rd_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_valid_owner", 32'(rd_valid), 32'(e.who));
                    chk("rd_data", 32'(rd_data), 32'(e.data));
                    chk("rd_latency", 32'(cyc), 32'(e.due));
                    $display("[TB] cyc %0d rd_valid=%b rd_data=0x%0h", cyc, rd_valid, rd_data);
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                chk("missing_rd_valid", 32'(rd_valid), 32'(e.who));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        req     = '0;
        addr    = '0;
        repeat (2) @(negedge clock);
        req = 4'b1111;
        #1;
        chk("gnt_in_reset", 32'(gnt), 32'd0);
        chk("rom_addr_in_reset", 32'(rom_addr), 32'd0);
        chk("rd_valid_in_reset", 32'(rd_valid), 32'd0);
        @(negedge clock);
        req     = '0;
        reset_n = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 10; i++) step(4'b0000, 0, 0, 0, 0, 4'b0000, 1'b1);
        chk("busy_idle", 32'(busy_cnt), 32'd0);

        // Round-robin among 1..3 from rr_ptr=1.
        step(4'b1110, 0, 10'h011, 10'h022, 10'h033, 4'b0010, 1'b1);
        step(4'b1110, 0, 10'h011, 10'h022, 10'h033, 4'b0100, 1'b1);
        step(4'b1110, 0, 10'h011, 10'h022, 10'h033, 4'b1000, 1'b1);
        step(4'b1110, 0, 10'h111, 10'h222, 10'h333, 4'b0010, 1'b1);
        step(4'b1110, 0, 10'h111, 10'h222, 10'h333, 4'b0100, 1'b1);
        step(4'b1110, 0, 10'h111, 10'h222, 10'h333, 4'b1000, 1'b1);
        step(4'b0000, 0, 0, 0, 0, 4'b0000, 1'b1);
        chk("busy_after_rr", 32'(busy_cnt), 32'd6);

        // Single pixel-path read.
        step(4'b0001, 10'h155, 0, 0, 0, 4'b0001, 1'b1);
        step(4'b0000, 0, 0, 0, 0, 4'b0000, 1'b1);

        // Back-to-back requester 0 stream.
        for (int i = 0; i < 4; i++) step(4'b0001, AW'(i), 0, 0, 0, 4'b0001, 1'b1);
        step(4'b0000, 0, 0, 0, 0, 4'b0000, 1'b1);

        // Starvation: requester 2 forced on the 7th cycle.
        for (int i = 0; i < 6; i++) step(4'b0101, 10'h040, 0, 10'h3A7, 0, 4'b0001, 1'b1);
        step(4'b0101, 10'h040, 0, 10'h3A7, 0, 4'b0100, 1'b1);
        for (int i = 0; i < 6; i++) step(4'b0101, 10'h041, 0, 10'h2C9, 0, 4'b0001, 1'b1);
        step(4'b0101, 10'h041, 0, 10'h2C9, 0, 4'b0100, 1'b1);
        step(4'b0000, 0, 0, 0, 0, 4'b0000, 1'b1);
        chk("busy_after_starve", 32'(busy_cnt), 32'(n_gr));

        // Reset in the cycle after a grant: rr_ptr would be 3 without reset.
        step(4'b0100, 0, 0, 10'h0F0, 0, 4'b0100, 1'b1);
        step(4'b1000, 0, 0, 0, 10'h0AB, 4'b1000, 1'b0);
        chk("rd_valid_before_reset", 32'(rd_valid), 32'b0100);
        reset_n = 1'b0;
        #1;
        chk("rd_valid_drops_on_reset", 32'(rd_valid), 32'd0);
        chk("busy_cleared", 32'(busy_cnt), 32'd0);
        @(negedge clock);
        req     = '0;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) step(4'b0000, 0, 0, 0, 0, 4'b0000, 1'b1);
        chk("no_stale_rd_valid", 32'(rd_valid), 32'd0);
        step(4'b1110, 0, 10'h301, 10'h302, 10'h303, 4'b0010, 1'b1);
        step(4'b0000, 0, 0, 0, 0, 4'b0000, 1'b1);
        chk("busy_after_reset", 32'(busy_cnt), 32'd1);

        repeat (3) @(negedge clock);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
